// File: rtl/cnn_layer_accel_job_dispatcher_if.sv
// Job-dispatcher bus: host job stream, per-quad job/fetch/complete
// handshakes, the shared fetch port and status.
interface cnn_layer_accel_job_dispatcher_if #(
  parameter int C_NUM_QUADS = 4,
  parameter int C_JOB_WIDTH = 128,
  parameter int C_CNT_WIDTH = 16
);
  localparam int C_QUAD_W = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1;

  logic                   job_in_valid;
  logic                   job_in_ready;
  logic [C_JOB_WIDTH-1:0] job_in_data;
  logic [C_NUM_QUADS-1:0] quad_enable;
  logic [C_NUM_QUADS-1:0] job_start;
  logic [C_NUM_QUADS-1:0] job_accept;
  logic [C_JOB_WIDTH-1:0] job_parameters;
  logic [C_NUM_QUADS-1:0] job_fetch_request;
  logic [C_NUM_QUADS-1:0] job_fetch_ack;
  logic [C_NUM_QUADS-1:0] job_fetch_complete;
  logic [C_QUAD_W-1:0]    fetch_quad;
  logic                   fetch_busy;
  logic                   fetch_done;
  logic [C_NUM_QUADS-1:0] job_complete;
  logic [C_NUM_QUADS-1:0] job_complete_ack;
  logic [C_NUM_QUADS-1:0] quad_busy;
  logic [C_CNT_WIDTH-1:0] jobs_completed;
  logic                   proto_err;

  // Dispatcher side
  modport master (
    input  job_in_valid, job_in_data, quad_enable, job_accept,
           job_fetch_request, fetch_done, job_complete,
    output job_in_ready, job_start, job_parameters, job_fetch_ack,
           job_fetch_complete, fetch_quad, fetch_busy, job_complete_ack,
           quad_busy, jobs_completed, proto_err
  );

  // Host / quad / memory side
  modport slave (
    output job_in_valid, job_in_data, quad_enable, job_accept,
           job_fetch_request, fetch_done, job_complete,
    input  job_in_ready, job_start, job_parameters, job_fetch_ack,
           job_fetch_complete, fetch_quad, fetch_busy, job_complete_ack,
           quad_busy, jobs_completed, proto_err
  );
endinterface

// File: rtl/cnn_layer_accel_job_dispatcher.sv
// Multi-quad job dispatcher: descriptor FIFO, round-robin dispatch to
// enabled idle quads, one shared fetch port arbitrated round-robin among
// running quads, completion acks with a wrapping completed-job counter,
// and a sticky protocol-error flag.
module cnn_layer_accel_job_dispatcher #(
  parameter int C_NUM_QUADS  = 4,
  parameter int C_JOB_WIDTH  = 128,
  parameter int C_FIFO_DEPTH = 8,
  parameter int C_CNT_WIDTH  = 16
) (
  input logic clk_core,
  input logic rst,
  cnn_layer_accel_job_dispatcher_if.master bus
);
  localparam int Q_W = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1;
  localparam int P_W = $clog2(C_FIFO_DEPTH);

  typedef enum logic [1:0] {Q_IDLE, Q_START, Q_RUN, Q_FETCH} q_state_t;

  q_state_t               state_q [C_NUM_QUADS];
  logic [C_JOB_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
  logic [P_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [P_W:0]           count_q;
  logic                   ready_q, avail_q;
  logic [Q_W-1:0]         disp_ptr_q, fetch_ptr_q, fetch_quad_q;
  logic                   fetch_busy_q, proto_err_q;
  logic [C_JOB_WIDTH-1:0] job_param_q;
  logic [C_NUM_QUADS-1:0] fetch_ack_q, fetch_cmpl_q, cmpl_ack_q;
  logic [C_CNT_WIDTH-1:0] jobs_cnt_q;

  logic [C_NUM_QUADS-1:0] start_vec, busy_vec, elig, run_req, cmpl_ok;
  logic                   any_start, dispatch, grant, push, pop, err;
  logic [Q_W-1:0]         disp_tgt, fetch_tgt;
  logic [C_CNT_WIDTH-1:0] cnt_add;
  logic [P_W:0]           count_d;

  // First requester at or after 'from', wrapping modulo C_NUM_QUADS.
  function automatic logic [Q_W-1:0] rr_pick(input logic [C_NUM_QUADS-1:0] req,
                                             input logic [Q_W-1:0] from);
    logic [C_NUM_QUADS-1:0] rot;
    logic [Q_W-1:0]         sel;
    logic                   found;
    rot   = C_NUM_QUADS'({req, req} >> from);
    sel   = from;
    found = 1'b0;
    for (int k = 0; k < C_NUM_QUADS; k++) begin
      if (!found && rot[k]) begin
        sel   = Q_W'((int'(from) + k) % C_NUM_QUADS);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Index after 'cur', wrapping at C_NUM_QUADS (need not be a power of 2).
  function automatic logic [Q_W-1:0] rr_next(input logic [Q_W-1:0] cur);
    return (int'(cur) == C_NUM_QUADS - 1) ? '0 : cur + 1'b1;
  endfunction

  // Per-quad qualification, dispatch/grant decisions and error detection.
  always_comb begin
    start_vec = '0;
    busy_vec  = '0;
    elig      = '0;
    run_req   = '0;
    cmpl_ok   = '0;
    cnt_add   = '0;
    err       = 1'b0;
    for (int i = 0; i < C_NUM_QUADS; i++) begin
      start_vec[i] = (state_q[i] == Q_START);
      busy_vec[i]  = (state_q[i] != Q_IDLE);
      elig[i]      = bus.quad_enable[i] && (state_q[i] == Q_IDLE);
      cmpl_ok[i]   = bus.job_complete[i] && (state_q[i] == Q_RUN);
      // A completing quad's fetch request is dropped: completion wins.
      run_req[i]   = bus.job_fetch_request[i] && !bus.job_complete[i] &&
                     (state_q[i] == Q_RUN);
      cnt_add      = cnt_add + C_CNT_WIDTH'(cmpl_ok[i]);
      if (bus.job_complete[i] && (state_q[i] == Q_START || state_q[i] == Q_FETCH))
        err = 1'b1;
      if (bus.job_accept[i] && (state_q[i] != Q_START))
        err = 1'b1;
    end
    if (bus.fetch_done && !fetch_busy_q)
      err = 1'b1;
    any_start = |start_vec;
    // avail_q delays offering a freshly written head by one cycle, so the
    // FIFO read always has a full cycle before it lands in job_parameters.
    dispatch  = (count_q != '0) && avail_q && !any_start && (|elig);
    disp_tgt  = rr_pick(elig, disp_ptr_q);
    grant     = !fetch_busy_q && (|run_req);
    fetch_tgt = rr_pick(run_req, fetch_ptr_q);
    push      = bus.job_in_valid && ready_q;
    pop       = dispatch;
    count_d   = count_q + (P_W+1)'(push) - (P_W+1)'(pop);
  end

  // Descriptor storage; data only, needs no reset.
  always_ff @(posedge clk_core) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.job_in_data;
  end

  // FIFO control, quad FSMs, fetch arbiter, counter and error flag.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      avail_q      <= 1'b0;
      disp_ptr_q   <= '0;
      fetch_ptr_q  <= '0;
      fetch_quad_q <= '0;
      fetch_busy_q <= 1'b0;
      proto_err_q  <= 1'b0;
      job_param_q  <= '0;
      fetch_ack_q  <= '0;
      fetch_cmpl_q <= '0;
      cmpl_ack_q   <= '0;
      jobs_cnt_q   <= '0;
      for (int i = 0; i < C_NUM_QUADS; i++) state_q[i] <= Q_IDLE;
    end else begin
      fetch_ack_q  <= '0;
      fetch_cmpl_q <= '0;
      cmpl_ack_q   <= cmpl_ok;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      ready_q    <= (count_d < (P_W+1)'(C_FIFO_DEPTH));
      avail_q    <= (count_q != '0);
      jobs_cnt_q <= jobs_cnt_q + cnt_add;
      if (err) proto_err_q <= 1'b1;
      if (dispatch) begin
        job_param_q <= fifo_mem[rd_ptr_q];
        disp_ptr_q  <= rr_next(disp_tgt);
      end
      if (fetch_done_ok()) begin
        fetch_busy_q               <= 1'b0;
        fetch_cmpl_q[fetch_quad_q] <= 1'b1;
      end else if (grant) begin
        fetch_busy_q           <= 1'b1;
        fetch_quad_q           <= fetch_tgt;
        fetch_ack_q[fetch_tgt] <= 1'b1;
        fetch_ptr_q            <= rr_next(fetch_tgt);
      end
      for (int i = 0; i < C_NUM_QUADS; i++) begin
        case (state_q[i])
          Q_IDLE:  if (dispatch && disp_tgt == Q_W'(i)) state_q[i] <= Q_START;
          Q_START: if (bus.job_accept[i]) state_q[i] <= Q_RUN;
          Q_RUN: begin
            if (cmpl_ok[i])                            state_q[i] <= Q_IDLE;
            else if (grant && fetch_tgt == Q_W'(i))    state_q[i] <= Q_FETCH;
          end
          Q_FETCH: if (fetch_done_ok() && fetch_quad_q == Q_W'(i)) state_q[i] <= Q_RUN;
          default: state_q[i] <= Q_IDLE;
        endcase
      end
    end
  end

  // A fetch_done only counts while a fetch is actually outstanding.
  function automatic logic fetch_done_ok();
    return bus.fetch_done && fetch_busy_q;
  endfunction

  assign bus.job_in_ready       = ready_q;
  assign bus.job_start          = start_vec;
  assign bus.job_parameters     = job_param_q;
  assign bus.job_fetch_ack      = fetch_ack_q;
  assign bus.job_fetch_complete = fetch_cmpl_q;
  assign bus.fetch_quad         = fetch_quad_q;
  assign bus.fetch_busy         = fetch_busy_q;
  assign bus.job_complete_ack   = cmpl_ack_q;
  assign bus.quad_busy          = busy_vec;
  assign bus.jobs_completed     = jobs_cnt_q;
  assign bus.proto_err          = proto_err_q;
endmodule

// File: tb/tb_cnn_layer_accel_job_dispatcher.sv
// Directed bench for the multi-quad job dispatcher: reset, dispatch order
// and latency, FIFO back-pressure, fetch arbitration, quad enables,
// simultaneous completions, protocol errors and mid-operation reset.
module tb_cnn_layer_accel_job_dispatcher;
  localparam int NQ    = 4;
  localparam int JW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic clk_core = 1'b0;
  logic rst      = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;

  logic          auto_accept   = 1'b0;
  logic          auto_complete = 1'b0;
  logic [NQ-1:0] man_accept    = '0;
  logic [NQ-1:0] man_complete  = '0;

  int            log_q[$];
  logic [JW-1:0] log_p[$];
  int            log_c[$];

  cnn_layer_accel_job_dispatcher_if #(.C_NUM_QUADS(NQ), .C_JOB_WIDTH(JW), .C_CNT_WIDTH(CW)) bus ();

  cnn_layer_accel_job_dispatcher #(
    .C_NUM_QUADS(NQ), .C_JOB_WIDTH(JW), .C_FIFO_DEPTH(DEPTH), .C_CNT_WIDTH(CW)
  ) dut (
    .clk_core(clk_core),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) cyc <= cyc + 1;

  // Quad model: accept whatever is started, complete whatever is running.
  assign bus.job_accept   = auto_accept ? bus.job_start : man_accept;
  assign bus.job_complete = man_complete |
                            (auto_complete ? (bus.quad_busy & ~bus.job_start) : '0);

  // Log every accepted start: quad, descriptor and edge index.
  always @(negedge clk_core) begin
    #1;
    for (int i = 0; i < NQ; i++)
      if (bus.job_start[i] && bus.job_accept[i]) begin
        log_q.push_back(i);
        log_p.push_back(bus.job_parameters);
        log_c.push_back(cyc);
      end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    auto_accept           = 1'b0;
    auto_complete         = 1'b0;
    man_accept            = '0;
    man_complete          = '0;
    bus.job_in_valid      = 1'b0;
    bus.job_in_data       = '0;
    bus.quad_enable       = '1;
    bus.job_fetch_request = '0;
    bus.fetch_done        = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) @(negedge clk_core);
    rst = 1'b1;
    @(negedge clk_core);
    log_q.delete();
    log_p.delete();
    log_c.delete();
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [JW-1:0] d, output int edge_no);
    int guard = 0;
    if (!bus.job_in_ready) bus.job_in_valid = 1'b0;
    while (!bus.job_in_ready && guard < 200) begin
      @(negedge clk_core);
      guard++;
    end
    if (!bus.job_in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL push_ready_timeout: job_in_ready=%b required 1", bus.job_in_ready);
    end
    bus.job_in_valid = 1'b1;
    bus.job_in_data  = d;
    edge_no          = cyc + 1;
    @(negedge clk_core);
  endtask

  task automatic wait_log(input int n, input int budget);
    int t = 0;
    while (log_q.size() < n && t < budget) begin
      @(negedge clk_core);
      t++;
    end
    @(negedge clk_core);
    n_cmp++;
    if (log_q.size() < n) begin
      n_bad++;
      $display("FAIL wait_starts: %0d accepted starts, required %0d", log_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int e;
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk_core);
    n_cmp++;
    if ({bus.job_in_ready, bus.job_start, bus.job_fetch_ack, bus.job_fetch_complete,
         bus.fetch_busy, bus.job_complete_ack, bus.quad_busy, bus.proto_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b start=%b fack=%b fcmp=%b fbusy=%b cack=%b qbusy=%b err=%b required all 0",
               bus.job_in_ready, bus.job_start, bus.job_fetch_ack, bus.job_fetch_complete,
               bus.fetch_busy, bus.job_complete_ack, bus.quad_busy, bus.proto_err);
    end
    n_cmp++;
    if ({bus.job_parameters, bus.fetch_quad, bus.jobs_completed} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: params=%h fquad=%0d count=%0d required 0",
               bus.job_parameters, bus.fetch_quad, bus.jobs_completed);
    end
    rst = 1'b1;
    @(negedge clk_core);
    n_cmp++;
    if (bus.job_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b required 1", bus.job_in_ready);
    end
    e = 0;
  endtask

  task automatic test_dispatch_order();
    int first, e;
    apply_reset();
    auto_accept = 1'b1;
    push(32'h1, first);
    for (int i = 2; i <= 4; i++) push(JW'(i), e);
    bus.job_in_valid = 1'b0;
    wait_log(4, 50);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= log_q.size() || log_q[i] !== i || log_p[i] !== JW'(i + 1)) begin
        n_bad++;
        $display("FAIL dispatch_order[%0d]: quad=%0d params=%h required quad=%0d params=%h",
                 i, (i < log_q.size()) ? log_q[i] : -1, (i < log_p.size()) ? log_p[i] : '0, i, i + 1);
      end
    end
    n_cmp++;
    if (log_c.size() == 0 || log_c[0] - first !== 2) begin
      n_bad++;
      $display("FAIL dispatch_latency: start edge %0d push edge %0d required diff 2",
               (log_c.size() > 0) ? log_c[0] : -1, first);
    end
    n_cmp++;
    if (bus.quad_busy !== 4'hF) begin
      n_bad++;
      $display("FAIL dispatch_busy: quad_busy=%b required 1111", bus.quad_busy);
    end
  endtask

  task automatic test_fifo_full();
    int e;
    apply_reset();
    for (int i = 0; i < 9; i++) push(JW'(32'h10 + i), e);
    bus.job_in_valid = 1'b0;
    n_cmp++;
    if (bus.job_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_full_ready: got %b required 0", bus.job_in_ready);
    end
    n_cmp++;
    if (bus.job_start !== 4'b0001 || bus.job_parameters !== 32'h10) begin
      n_bad++;
      $display("FAIL fifo_held_start: start=%b params=%h required 0001/00000010",
               bus.job_start, bus.job_parameters);
    end
    auto_accept   = 1'b1;
    auto_complete = 1'b1;
    wait_log(9, 200);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (i >= log_q.size() || log_p[i] !== JW'(32'h10 + i) || log_q[i] !== i % 4) begin
        n_bad++;
        $display("FAIL fifo_drain[%0d]: quad=%0d params=%h required quad=%0d params=%h",
                 i, (i < log_q.size()) ? log_q[i] : -1, (i < log_p.size()) ? log_p[i] : '0,
                 i % 4, 32'h10 + i);
      end
    end
    repeat (4) @(negedge clk_core);
    n_cmp++;
    if (bus.jobs_completed !== 16'd9 || bus.job_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fifo_drain_done: count=%0d ready=%b required 9/1",
               bus.jobs_completed, bus.job_in_ready);
    end
  endtask

  task automatic test_fetch_arb();
    int e;
    apply_reset();
    auto_accept = 1'b1;
    for (int i = 1; i <= 4; i++) push(JW'(i), e);
    bus.job_in_valid = 1'b0;
    wait_log(4, 50);
    bus.job_fetch_request = 4'b1010;
    @(negedge clk_core);
    n_cmp++;
    if (bus.job_fetch_ack !== 4'b0010 || bus.fetch_busy !== 1'b1 || bus.fetch_quad !== 2'd1) begin
      n_bad++;
      $display("FAIL fetch_grant1: ack=%b busy=%b fquad=%0d required 0010/1/1",
               bus.job_fetch_ack, bus.fetch_busy, bus.fetch_quad);
    end
    bus.job_fetch_request = 4'b1000;
    @(negedge clk_core);
    n_cmp++;
    if (bus.job_fetch_ack !== 4'b0000 || bus.fetch_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_hold: ack=%b busy=%b required 0000/1", bus.job_fetch_ack, bus.fetch_busy);
    end
    bus.fetch_done = 1'b1;
    @(negedge clk_core);
    bus.fetch_done = 1'b0;
    n_cmp++;
    if (bus.job_fetch_complete !== 4'b0010 || bus.fetch_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_done1: fcmp=%b busy=%b required 0010/0",
               bus.job_fetch_complete, bus.fetch_busy);
    end
    @(negedge clk_core);
    n_cmp++;
    if (bus.job_fetch_ack !== 4'b1000 || bus.fetch_quad !== 2'd3 || bus.job_fetch_complete !== 4'b0000) begin
      n_bad++;
      $display("FAIL fetch_grant3: ack=%b fquad=%0d fcmp=%b required 1000/3/0000",
               bus.job_fetch_ack, bus.fetch_quad, bus.job_fetch_complete);
    end
    bus.job_fetch_request = '0;
    bus.fetch_done        = 1'b1;
    @(negedge clk_core);
    bus.fetch_done = 1'b0;
    n_cmp++;
    if (bus.job_fetch_complete !== 4'b1000 || bus.proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_done3: fcmp=%b err=%b required 1000/0",
               bus.job_fetch_complete, bus.proto_err);
    end
  endtask

  task automatic test_enable();
    int e, ack_edge;
    apply_reset();
    bus.quad_enable = 4'b0101;
    auto_accept     = 1'b1;
    for (int i = 1; i <= 4; i++) push(JW'(32'h20 + i), e);
    bus.job_in_valid = 1'b0;
    wait_log(2, 50);
    repeat (4) @(negedge clk_core);
    n_cmp++;
    if (log_q.size() != 2 || log_q[0] !== 0 || log_q[1] !== 2 ||
        log_p[0] !== 32'h21 || log_p[1] !== 32'h22) begin
      n_bad++;
      $display("FAIL enable_dispatch: %0d starts, required 2 (q0=21, q2=22)", log_q.size());
    end
    man_complete = 4'b0001;
    @(negedge clk_core);
    man_complete = '0;
    ack_edge     = cyc;
    n_cmp++;
    if (bus.job_complete_ack !== 4'b0001) begin
      n_bad++;
      $display("FAIL enable_ack: ack=%b required 0001", bus.job_complete_ack);
    end
    wait_log(3, 20);
    repeat (3) @(negedge clk_core);
    n_cmp++;
    if (log_q.size() != 3 || log_q[2] !== 0 || log_p[2] !== 32'h23 || log_c[2] !== ack_edge + 1) begin
      n_bad++;
      $display("FAIL enable_redispatch: starts=%0d quad=%0d params=%h edge=%0d required 3/0/23/%0d",
               log_q.size(), (log_q.size() > 2) ? log_q[2] : -1,
               (log_p.size() > 2) ? log_p[2] : '0, (log_c.size() > 2) ? log_c[2] : -1, ack_edge + 1);
    end
  endtask

  task automatic test_complete_err();
    int e;
    apply_reset();
    auto_accept = 1'b1;
    for (int i = 1; i <= 3; i++) push(JW'(32'h40 + i), e);
    bus.job_in_valid = 1'b0;
    wait_log(3, 50);
    n_cmp++;
    if (bus.jobs_completed !== 16'd0) begin
      n_bad++;
      $display("FAIL cmpl_pre: count=%0d required 0", bus.jobs_completed);
    end
    man_complete = 4'b0101;
    @(negedge clk_core);
    man_complete = '0;
    n_cmp++;
    if (bus.job_complete_ack !== 4'b0101 || bus.jobs_completed !== 16'd2) begin
      n_bad++;
      $display("FAIL cmpl_dual: ack=%b count=%0d required 0101/2",
               bus.job_complete_ack, bus.jobs_completed);
    end
    @(negedge clk_core);
    n_cmp++;
    if (bus.job_complete_ack !== 4'b0000 || bus.proto_err !== 1'b0 || bus.quad_busy !== 4'b0010) begin
      n_bad++;
      $display("FAIL cmpl_after: ack=%b err=%b qbusy=%b required 0000/0/0010",
               bus.job_complete_ack, bus.proto_err, bus.quad_busy);
    end
    bus.fetch_done = 1'b1;
    @(negedge clk_core);
    bus.fetch_done = 1'b0;
    @(negedge clk_core);
    n_cmp++;
    if (bus.proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_stray_done: proto_err=%b required 1", bus.proto_err);
    end
    apply_reset();
    auto_accept = 1'b0;
    man_accept  = 4'b0100;
    @(negedge clk_core);
    man_accept = '0;
    n_cmp++;
    if (bus.proto_err !== 1'b1 || bus.quad_busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL err_idle_accept: proto_err=%b qbusy=%b required 1/0000",
               bus.proto_err, bus.quad_busy);
    end
  endtask

  task automatic test_reset_midfetch();
    int e;
    apply_reset();
    bus.quad_enable = 4'b0001;
    auto_accept     = 1'b1;
    for (int i = 1; i <= 4; i++) push(JW'(32'h30 + i), e);
    bus.job_in_valid = 1'b0;
    wait_log(1, 50);
    bus.job_fetch_request = 4'b0001;
    @(negedge clk_core);
    n_cmp++;
    if (bus.fetch_busy !== 1'b1 || bus.quad_busy !== 4'b0001 || bus.job_parameters !== 32'h31) begin
      n_bad++;
      $display("FAIL midfetch_pre: busy=%b qbusy=%b params=%h required 1/0001/31",
               bus.fetch_busy, bus.quad_busy, bus.job_parameters);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.job_in_ready, bus.job_start, bus.fetch_busy, bus.quad_busy, bus.proto_err,
         bus.job_fetch_ack, bus.job_fetch_complete, bus.job_complete_ack} !== '0 ||
        {bus.job_parameters, bus.fetch_quad, bus.jobs_completed} !== '0) begin
      n_bad++;
      $display("FAIL midfetch_async: ready=%b start=%b fbusy=%b qbusy=%b params=%h required all 0",
               bus.job_in_ready, bus.job_start, bus.fetch_busy, bus.quad_busy, bus.job_parameters);
    end
    drive_idle();
    bus.quad_enable = 4'b0001;
    @(negedge clk_core);
    rst = 1'b1;
    repeat (3) @(negedge clk_core);
    n_cmp++;
    if (bus.job_in_ready !== 1'b1 || bus.jobs_completed !== 16'd0 || bus.quad_busy !== 4'b0000 ||
        bus.job_start !== 4'b0000 || bus.job_complete_ack !== 4'b0000 || bus.job_fetch_complete !== 4'b0000) begin
      n_bad++;
      $display("FAIL midfetch_release: ready=%b count=%0d qbusy=%b start=%b cack=%b fcmp=%b required 1/0/0/0/0/0",
               bus.job_in_ready, bus.jobs_completed, bus.quad_busy, bus.job_start,
               bus.job_complete_ack, bus.job_fetch_complete);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch_order();
    test_fifo_full();
    test_fetch_arb();
    test_enable();
    test_complete_err();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
